// File: rtl/video_dma_if.sv
`default_nettype none
// ============================================================================
// video_dma_if : CPU iomem responder bus plus video-side write initiator bus
// Rev 1.0
// ============================================================================
interface video_dma_if;
    logic        iomem_valid;
    logic        iomem_ready;
    logic [3:0]  iomem_wstrb;
    logic [31:0] iomem_addr;
    logic [31:0] iomem_wdata;
    logic [31:0] iomem_rdata;
    logic        vid_valid;
    logic        vid_ready;
    logic [3:0]  vid_wstrb;
    logic [31:0] vid_addr;
    logic [31:0] vid_wdata;
    logic        dma_done;

    modport slave (
        input  iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
        output iomem_ready, iomem_rdata,
        output vid_valid, vid_wstrb, vid_addr, vid_wdata,
        input  vid_ready,
        output dma_done
    );

    modport master (
        output iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
        input  iomem_ready, iomem_rdata,
        input  vid_valid, vid_wstrb, vid_addr, vid_wdata,
        output vid_ready,
        input  dma_done
    );
endinterface
`default_nettype wire

// File: rtl/video_dma.sv
`default_nettype none
// ============================================================================
// video_dma : fill engine writing strided word runs into the video iomem window
// Optional VIDEO_DMA_VSYNC_WAIT_EN adds a vblank input and a wait-for-vblank start.
// Rev 1.0
// ============================================================================
module video_dma #(
    parameter logic [31:0] DEST_BASE = 32'h0300_0000
) (
    input  wire logic  clk,
    input  wire logic  resetn,
`ifdef VIDEO_DMA_VSYNC_WAIT_EN
    input  wire logic  vblank,
`endif
    video_dma_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT_VB = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [23:0] dest_q;
    logic [15:0] count_q;
    logic [31:0] data_q;
    logic [15:0] stride_q;
    logic [23:0] cur_q;
    logic [15:0] rem_q;
    logic [31:0] word_q;
    logic [15:0] step_q;
    logic        inc_q;
    logic        done_q;
    logic        aborted_q;
    logic        abort_pend_q;
    logic        ready_q;
    logic        done_pulse_q;
    logic [31:0] rdata_q;

    logic [2:0]  sel;
    logic        wr_en, ctrl_wr, start_cmd, abort_cmd, clr_cmd;
    logic        busy, beat, abort_any, vsync_req;
    logic        load, finish, finish_abort;
    logic [31:0] wmask, rd_mux;
    logic        unused_addr;

    assign sel         = bus.iomem_addr[4:2];
    assign unused_addr = ^{bus.iomem_addr[31:5], bus.iomem_addr[1:0]};

    // Register writes land at the end of the ready cycle.
    assign wr_en     = bus.iomem_valid && ready_q && (bus.iomem_wstrb != 4'h0);
    assign ctrl_wr   = wr_en && (sel == 3'd4) && bus.iomem_wstrb[0];
    assign start_cmd = ctrl_wr && bus.iomem_wdata[0];
    assign abort_cmd = ctrl_wr && bus.iomem_wdata[1];
    assign clr_cmd   = ctrl_wr && bus.iomem_wdata[3];
    assign busy      = (state_q != ST_IDLE);
    assign beat      = (state_q == ST_ISSUE) && bus.vid_ready;
    assign abort_any = abort_pend_q || abort_cmd;
    assign wmask     = {{8{bus.iomem_wstrb[3]}}, {8{bus.iomem_wstrb[2]}},
                        {8{bus.iomem_wstrb[1]}}, {8{bus.iomem_wstrb[0]}}};

`ifdef VIDEO_DMA_VSYNC_WAIT_EN
    logic vb_q, vb_qq, vb_rise;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            vb_q  <= 1'b0;
            vb_qq <= 1'b0;
        end else begin
            vb_q  <= vblank;
            vb_qq <= vb_q;
        end
    end

    assign vb_rise   = vb_q && !vb_qq;
    assign vsync_req = bus.iomem_wdata[4];
`else
    assign vsync_req = 1'b0;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        load         = 1'b0;
        finish       = 1'b0;
        finish_abort = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_cmd) begin
                    if (count_q == 16'd0) begin
                        finish = 1'b1;
                    end else begin
                        load    = 1'b1;
                        state_d = vsync_req ? ST_WAIT_VB : ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                // A pending abort only takes effect on a handshake, so a beat is never cut.
                if (beat && ((rem_q == 16'd1) || abort_any)) begin
                    state_d      = ST_IDLE;
                    finish       = 1'b1;
                    finish_abort = abort_any;
                end
            end
`ifdef VIDEO_DMA_VSYNC_WAIT_EN
            ST_WAIT_VB: begin
                if (abort_any) begin
                    state_d      = ST_IDLE;
                    finish       = 1'b1;
                    finish_abort = 1'b1;
                end else if (vb_rise) begin
                    state_d = ST_ISSUE;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rd_mux = 32'h0;
        case (sel)
            3'd0:    rd_mux = {8'h0, dest_q};
            3'd1:    rd_mux = {16'h0, busy ? rem_q : count_q};
            3'd2:    rd_mux = data_q;
            3'd3:    rd_mux = {16'h0, stride_q};
            3'd4:    rd_mux = {rem_q, 13'h0, aborted_q, done_q, busy};
            default: rd_mux = 32'h0;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            dest_q       <= 24'h0;
            count_q      <= 16'h0;
            data_q       <= 32'h0;
            stride_q     <= 16'h0;
            cur_q        <= 24'h0;
            rem_q        <= 16'h0;
            word_q       <= 32'h0;
            step_q       <= 16'h0;
            inc_q        <= 1'b0;
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
            abort_pend_q <= 1'b0;
            ready_q      <= 1'b0;
            done_pulse_q <= 1'b0;
            rdata_q      <= 32'h0;
        end else begin
            ready_q      <= bus.iomem_valid && !ready_q;
            rdata_q      <= (bus.iomem_valid && !ready_q) ? rd_mux : 32'h0;
            done_pulse_q <= finish;

            if (wr_en && !busy) begin
                case (sel)
                    3'd0: dest_q   <= (dest_q & ~wmask[23:0]) | (bus.iomem_wdata[23:0] & wmask[23:0]);
                    3'd1: count_q  <= (count_q & ~wmask[15:0]) | (bus.iomem_wdata[15:0] & wmask[15:0]);
                    3'd2: data_q   <= (data_q & ~wmask) | (bus.iomem_wdata & wmask);
                    3'd3: stride_q <= (stride_q & ~wmask[15:0]) | (bus.iomem_wdata[15:0] & wmask[15:0]);
                    default: ;
                endcase
            end

            if (load) begin
                cur_q  <= dest_q;
                rem_q  <= count_q;
                word_q <= data_q;
                step_q <= stride_q;
                inc_q  <= bus.iomem_wdata[2];
            end else if (beat) begin
                cur_q  <= cur_q + {8'h0, step_q};
                rem_q  <= rem_q - 16'd1;
                word_q <= word_q + {31'h0, inc_q};
            end

            if (finish) begin
                done_q       <= 1'b1;
                aborted_q    <= finish_abort;
                abort_pend_q <= 1'b0;
            end else if (load) begin
                done_q       <= 1'b0;
                aborted_q    <= 1'b0;
                abort_pend_q <= 1'b0;
            end else begin
                if (clr_cmd) begin
                    done_q    <= 1'b0;
                    aborted_q <= 1'b0;
                end
                if (abort_cmd && busy) abort_pend_q <= 1'b1;
            end
        end
    end

    assign bus.iomem_ready = ready_q;
    assign bus.iomem_rdata = rdata_q;
    assign bus.vid_valid   = (state_q == ST_ISSUE);
    assign bus.vid_wstrb   = 4'hF;
    assign bus.vid_addr    = {DEST_BASE[31:24], cur_q};
    assign bus.vid_wdata   = word_q;
    assign bus.dma_done    = done_pulse_q;
endmodule
`default_nettype wire

// File: tb/tb_video_dma.sv
`default_nettype none
// ============================================================================
// tb_video_dma : randomized self-checking bench for video_dma
// Rev 1.0
// ============================================================================
module tb_video_dma;
    localparam logic [31:0] BASE    = 32'h0300_0000;
    localparam logic [7:0]  BASE_HI = 8'h03;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    logic vblank = 1'b0;
    always #5 clk = ~clk;

    video_dma_if bus ();

    video_dma #(.DEST_BASE(BASE)) dut (
        .clk   (clk),
        .resetn(resetn),
`ifdef VIDEO_DMA_VSYNC_WAIT_EN
        .vblank(vblank),
`endif
        .bus   (bus)
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    logic rand_mode = 1'b0;
    logic rdy_force = 1'b1;
    logic rand_bit  = 1'b0;

    assign bus.vid_ready = rand_mode ? rand_bit : rdy_force;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rand_bit <= ($urandom_range(0, 3) != 0);
    end

    // Passive monitor: records every accepted beat and every done pulse.
    logic [31:0] obs_addr[$];
    logic [31:0] obs_data[$];
    int          obs_cyc[$];
    int          done_cnt     = 0;
    int          done_cyc     = 0;
    int          valid_cycles = 0;
    int          stab_viol    = 0;
    logic        prev_stall   = 1'b0;
    logic [31:0] prev_addr    = 32'h0;
    logic [31:0] prev_data    = 32'h0;

    always @(negedge clk) begin
        if (bus.vid_valid === 1'b1) valid_cycles++;
        if (bus.vid_valid === 1'b1 && prev_stall &&
            (bus.vid_addr !== prev_addr || bus.vid_wdata !== prev_data)) stab_viol++;
        if (bus.vid_valid === 1'b1 && bus.vid_ready === 1'b1) begin
            obs_addr.push_back(bus.vid_addr);
            obs_data.push_back(bus.vid_wdata);
            obs_cyc.push_back(cyc);
        end
        if (bus.dma_done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
        prev_stall = (bus.vid_valid === 1'b1) && (bus.vid_ready !== 1'b1);
        prev_addr  = bus.vid_addr;
        prev_data  = bus.vid_wdata;
    end

    task automatic cpu_access(input logic [2:0] sel, input logic [31:0] wd,
                              input logic [3:0] st, output logic [31:0] rd);
        int k;
        @(posedge clk); #1;
        bus.iomem_valid = 1'b1;
        bus.iomem_addr  = {27'h0, sel, 2'b00};
        bus.iomem_wdata = wd;
        bus.iomem_wstrb = st;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (bus.iomem_ready !== 1'b1 && k < 8);
        rd = bus.iomem_rdata;
        n_checks++;
        if (bus.iomem_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL iomem_ready_timeout: ready=%b after %0d cycles, required 1", bus.iomem_ready, k);
        end
        @(posedge clk); #1;
        bus.iomem_valid = 1'b0;
        bus.iomem_wstrb = 4'h0;
    endtask

    task automatic wr(input logic [2:0] sel, input logic [31:0] wd);
        logic [31:0] dummy;
        cpu_access(sel, wd, 4'hF, dummy);
    endtask

    task automatic rd(input logic [2:0] sel, output logic [31:0] val);
        cpu_access(sel, 32'h0, 4'h0, val);
    endtask

    // One complete run: mode 0 ready high, 1 random ready, 2 ready low 3 cycles on beat 2.
    task automatic test_run(input string name, input logic [23:0] dest, input logic [15:0] count,
                            input logic [31:0] data, input logic [15:0] stride, input logic inc,
                            input int mode, output int s);
        int b, d0, v0, k;
        logic [31:0] off, exp_a, exp_d;
        rand_mode = 1'b0;
        rdy_force = 1'b1;
        wr(3'd0, {8'h0, dest});
        wr(3'd1, {16'h0, count});
        wr(3'd2, data);
        wr(3'd3, {16'h0, stride});
        b  = obs_addr.size();
        d0 = done_cnt;
        v0 = stab_viol;
        rand_mode = (mode == 1);
        wr(3'd4, {29'h0, inc, 2'b01});
        s = cyc;
        if (mode == 2) begin
            @(posedge clk); #1 rdy_force = 1'b0;
            repeat (3) @(posedge clk);
            #1 rdy_force = 1'b1;
        end
        k = 0;
        while (done_cnt == d0 && k < int'(count) * 8 + 40) begin
            @(negedge clk);
            k++;
        end
        repeat (3) @(negedge clk);
        rand_mode = 1'b0;
        n_checks++;
        if (obs_addr.size() - b != int'(count)) begin
            n_fail++;
            $display("FAIL %s beat_count: got %0d, required %0d", name, obs_addr.size() - b, count);
        end
        for (int i = 0; i < int'(count) && b + i < obs_addr.size(); i++) begin
            off   = 32'(dest) + 32'(i) * 32'(stride);
            exp_a = {BASE_HI, off[23:0]};
            exp_d = data + 32'(i) * 32'(inc);
            n_checks++;
            if (obs_addr[b+i] !== exp_a || obs_data[b+i] !== exp_d) begin
                n_fail++;
                $display("FAIL %s beat%0d: addr %h data %h, required %h %h",
                         name, i, obs_addr[b+i], obs_data[b+i], exp_a, exp_d);
            end
        end
        n_checks++;
        if (done_cnt - d0 != 1) begin
            n_fail++;
            $display("FAIL %s done_pulses: got %0d, required 1", name, done_cnt - d0);
        end
        n_checks++;
        if (stab_viol != v0) begin
            n_fail++;
            $display("FAIL %s stall_hold: %0d changes while stalled, required 0", name, stab_viol - v0);
        end
    endtask

    task automatic test_reset;
        logic [31:0] v;
        bus.iomem_valid = 1'b0;
        bus.iomem_wstrb = 4'h0;
        bus.iomem_addr  = 32'h0;
        bus.iomem_wdata = 32'h0;
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({bus.iomem_ready, bus.iomem_rdata, bus.vid_valid, bus.vid_addr, bus.vid_wdata,
             bus.vid_wstrb, bus.dma_done} !== {1'b0, 32'h0, 1'b0, BASE, 32'h0, 4'hF, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_outputs: ready=%b rdata=%h valid=%b addr=%h wdata=%h wstrb=%h done=%b, required 0 0 0 %h 0 f 0",
                     bus.iomem_ready, bus.iomem_rdata, bus.vid_valid, bus.vid_addr, bus.vid_wdata,
                     bus.vid_wstrb, bus.dma_done, BASE);
        end
        @(posedge clk); #1 resetn = 1'b1;
        for (int r = 0; r < 5; r++) begin
            rd(3'(r), v);
            n_checks++;
            if (v !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_reg%0d: got %h, required 00000000", r, v);
            end
        end
        cpu_access(3'd0, 32'hAABBCCDD, 4'b0010, v);
        rd(3'd0, v);
        n_checks++;
        if (v !== 32'h0000CC00) begin
            n_fail++;
            $display("FAIL byte_strobe: DEST %h, required 0000cc00", v);
        end
    endtask

    task automatic test_basic;
        int s, b;
        logic [31:0] v;
        test_run("basic", 24'h200000, 16'd4, 32'h41, 16'd4, 1'b1, 0, s);
        b = obs_cyc.size() - 4;
        for (int i = 0; i < 4 && b >= 0; i++) begin
            n_checks++;
            if (obs_cyc[b+i] != s + i) begin
                n_fail++;
                $display("FAIL basic_timing beat%0d: cycle %0d, required %0d", i, obs_cyc[b+i], s + i);
            end
        end
        n_checks++;
        if (done_cyc != s + 4) begin
            n_fail++;
            $display("FAIL basic_done_cycle: cycle %0d, required %0d", done_cyc, s + 4);
        end
        rd(3'd4, v);
        n_checks++;
        if (v !== 32'h0000_0002) begin
            n_fail++;
            $display("FAIL basic_status: got %h, required 00000002", v);
        end
    endtask

    task automatic test_stall;
        int s, v0;
        v0 = valid_cycles;
        test_run("stall", 24'h200000, 16'd4, 32'h41, 16'd4, 1'b1, 2, s);
        n_checks++;
        if (valid_cycles - v0 != 7) begin
            n_fail++;
            $display("FAIL stall_valid_cycles: got %0d, required 7", valid_cycles - v0);
        end
    endtask

    task automatic test_wrap;
        int s;
        test_run("wrap", 24'hFFFFFC, 16'd2, $urandom, 16'd8, 1'b0, 0, s);
    endtask

    task automatic test_abort;
        int b, d0;
        logic [23:0] dest;
        logic [31:0] data, v;
        dest = 24'($urandom) & 24'hFFFF00;
        data = $urandom;
        rand_mode = 1'b0;
        rdy_force = 1'b0;
        wr(3'd0, {8'h0, dest});
        wr(3'd1, 32'd100);
        wr(3'd2, data);
        wr(3'd3, 32'd4);
        b  = obs_addr.size();
        d0 = done_cnt;
        wr(3'd4, 32'h5);
        repeat (4) begin
            @(posedge clk); #1 rdy_force = 1'b1;
        end
        @(posedge clk); #1 rdy_force = 1'b0;
        wr(3'd4, 32'h2);
        @(posedge clk); #1 rdy_force = 1'b1;
        repeat (10) @(negedge clk);
        n_checks++;
        if (obs_addr.size() - b != 5) begin
            n_fail++;
            $display("FAIL abort_beats: got %0d, required 5", obs_addr.size() - b);
        end else begin
            n_checks++;
            if (obs_addr[b+4] !== {BASE_HI, dest + 24'd16} || obs_data[b+4] !== data + 32'd4) begin
                n_fail++;
                $display("FAIL abort_beat5: addr %h data %h, required %h %h",
                         obs_addr[b+4], obs_data[b+4], {BASE_HI, dest + 24'd16}, data + 32'd4);
            end
        end
        n_checks++;
        if (done_cnt - d0 != 1) begin
            n_fail++;
            $display("FAIL abort_done_pulses: got %0d, required 1", done_cnt - d0);
        end
        rd(3'd4, v);
        n_checks++;
        if (v !== {16'd95, 16'h0006}) begin
            n_fail++;
            $display("FAIL abort_status: got %h, required %h", v, {16'd95, 16'h0006});
        end
        rd(3'd1, v);
        n_checks++;
        if (v !== 32'd100) begin
            n_fail++;
            $display("FAIL abort_count_idle: got %0d, required 100", v);
        end
    endtask

    task automatic test_zero_and_busy;
        int v0, d0, b, k;
        logic [23:0] x;
        logic [31:0] v;
        rdy_force = 1'b1;
        v0 = valid_cycles;
        d0 = done_cnt;
        wr(3'd4, 32'h8);
        wr(3'd1, 32'd0);
        wr(3'd4, 32'h1);
        repeat (8) @(negedge clk);
        rd(3'd4, v);
        n_checks++;
        if (valid_cycles != v0 || done_cnt - d0 != 1 || v[2:0] !== 3'b010) begin
            n_fail++;
            $display("FAIL zero_count: valid_cycles %0d pulses %0d status %b, required 0 1 010",
                     valid_cycles - v0, done_cnt - d0, v[2:0]);
        end
        x = 24'($urandom) & 24'hFFFFF0;
        rdy_force = 1'b0;
        wr(3'd0, {8'h0, x});
        wr(3'd1, 32'd3);
        wr(3'd3, 32'd4);
        b  = obs_addr.size();
        d0 = done_cnt;
        wr(3'd4, 32'h1);
        wr(3'd0, {8'h0, ~x});
        rd(3'd0, v);
        n_checks++;
        if (v !== {8'h0, x}) begin
            n_fail++;
            $display("FAIL busy_dest_write: DEST %h, required %h", v, {8'h0, x});
        end
        rd(3'd1, v);
        n_checks++;
        if (v !== 32'd3) begin
            n_fail++;
            $display("FAIL busy_remaining: got %0d, required 3", v);
        end
        rdy_force = 1'b1;
        k = 0;
        while (done_cnt == d0 && k < 50) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (obs_addr.size() - b != 3 || obs_addr[b] !== {BASE_HI, x} || obs_addr[b+2] !== {BASE_HI, x + 24'd8}) begin
            n_fail++;
            $display("FAIL busy_run: beats %0d first addr %h, required 3 %h",
                     obs_addr.size() - b, (obs_addr.size() > b) ? obs_addr[b] : 32'hx, {BASE_HI, x});
        end
    endtask

    task automatic test_random;
        int s;
        for (int it = 0; it < 6; it++) begin
            test_run("random", 24'($urandom), 16'($urandom_range(1, 12)), $urandom,
                     16'($urandom), 1'($urandom), 1, s);
        end
    endtask

    task automatic test_reset_midrun;
        int n;
        rdy_force = 1'b1;
        wr(3'd0, 32'h0010_0000);
        wr(3'd1, 32'd50);
        wr(3'd3, 32'd4);
        wr(3'd4, 32'h1);
        repeat (5) @(posedge clk);
        #2 resetn = 1'b0;
        #1;
        n_checks++;
        if (bus.vid_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_midrun_valid: got %b, required 0", bus.vid_valid);
        end
        n = obs_addr.size();
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        repeat (10) @(negedge clk);
        n_checks++;
        if (obs_addr.size() != n || bus.vid_addr !== BASE) begin
            n_fail++;
            $display("FAIL reset_midrun_after: %0d new beats addr %h, required 0 %h",
                     obs_addr.size() - n, bus.vid_addr, BASE);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_wrap();
        test_abort();
        test_zero_and_busy();
        test_random();
        test_reset_midrun();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire
